// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller.
// State encoding, fault causes and PC arithmetic widths.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } state_t;

  function automatic logic misaligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: redirect, imem and decode handshakes.
// master = controller side, slave = core/memory side.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            fault;
  logic [1:0]      fault_cause;
  logic            fault_clear;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    output fault,
    output fault_cause,
    input  fault_clear
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    input  fault,
    input  fault_cause,
    output fault_clear
  );

endinterface

// File: rtl/fetch_wdog.sv
// Response watchdog: counts cycles spent waiting on imem.
// expired fires on the MAX_WAIT-th waiting cycle.
module fetch_wdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Compare against MAX_WAIT-1 so the fault lands exactly MAX_WAIT cycles in.
  assign expired = en && (cnt == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencing and single-outstanding instruction fetch.
// Handles redirects, decode stalls, misalignment and timeouts.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          MAX_WAIT  = 15
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  state_t          state;
  state_t          state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;
  logic [XLEN-1:0] ipc_q;
  logic [XLEN-1:0] ipc_d;
  logic            drop;
  logic            drop_d;
  logic [1:0]      cause;
  logic [1:0]      cause_d;
  logic            expired;
  logic            redir;
  logic            redir_ok;
  logic            redir_bad;
  logic            accept;

  assign redir     = bus.redirect_valid && (state != FAULT);
  assign redir_bad = redir && misaligned(bus.redirect_pc);
  assign redir_ok  = redir && !misaligned(bus.redirect_pc);
  assign accept    = (state == REQ) && bus.imem_req_ready;

  fetch_wdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT),
    .en      (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_VEC;
      data_q <= '0;
      ipc_q  <= '0;
      drop   <= 1'b0;
      cause  <= CAUSE_NONE;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      data_q <= data_d;
      ipc_q  <= ipc_d;
      drop   <= drop_d;
      cause  <= cause_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    data_d  = data_q;
    ipc_d   = ipc_q;
    drop_d  = drop;
    cause_d = cause;
    unique case (state)
      IDLE: begin
        state_d = REQ;
        if (redir_ok) pc_d = bus.redirect_pc;
      end
      REQ: begin
        if (redir_ok) pc_d = bus.redirect_pc;
        if (accept) begin
          state_d = WAIT;
          drop_d  = redir_ok;
        end
      end
      WAIT: begin
        if (redir_ok) begin
          pc_d   = bus.redirect_pc;
          drop_d = 1'b1;
        end
        // A same-cycle redirect discards the response too.
        if (bus.imem_rsp_valid) begin
          if (drop || redir_ok) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            data_d  = bus.imem_rsp_data;
            ipc_d   = pc;
            pc_d    = pc + PC_STEP;
            state_d = HOLD;
          end
        end else if (expired) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      HOLD: begin
        if (redir_ok) begin
          pc_d    = bus.redirect_pc;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          state_d = REQ;
        end
      end
      FAULT: begin
        drop_d = 1'b0;
        if (bus.fault_clear) begin
          state_d = REQ;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redir_bad) begin
      state_d = FAULT;
      cause_d = CAUSE_MISALIGN;
      pc_d    = pc;
      data_d  = data_q;
      ipc_d   = ipc_q;
      drop_d  = 1'b0;
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_addr      = pc;
  assign bus.inst_valid     = (state == HOLD);
  assign bus.inst_data      = data_q;
  assign bus.inst_pc        = ipc_q;
  assign bus.fault          = (state == FAULT);
  assign bus.fault_cause    = cause;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and instruction-memory fetch for the single-cycle core.
- Owns the architectural PC register.
- Issues one instruction-memory request at a time and presents fetched instructions to decode through a valid/ready handshake.
- Handles branch/jump redirects, downstream stalls, misaligned targets and memory-response timeouts.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, cycles spent in WAIT without imem_rsp_valid before a timeout fault; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address, equal to the current PC.
- imem_rsp_valid  in  1  instruction data returned.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  32  held instruction word.
- inst_pc  out  32  PC of the held instruction.
- fault  out  1  controller halted on a fault.
- fault_cause  out  2  0=none, 1=MISALIGN, 2=TIMEOUT.
- fault_clear  in  1  leave FAULT and resume fetching.

Behaviour:
- Reset (rst=1, async):
  - pc=RESET_VEC, state=IDLE, drop flag=0, wait counter=0.
  - All outputs 0, except imem_addr=RESET_VEC.
- States: IDLE, REQ, WAIT, HOLD, FAULT. Outputs are decoded from state and registers:
  - imem_req_valid=(state==REQ).
  - inst_valid=(state==HOLD).
  - fault=(state==FAULT).
  - imem_addr=pc.
- IDLE -> REQ unconditionally on the first clk after reset release.
- REQ:
  - On imem_req_valid & imem_req_ready: go to WAIT, clear the wait counter.
  - Otherwise hold in REQ with imem_addr stable.
- WAIT:
  - The counter increments each cycle.
  - On imem_rsp_valid with drop=0: latch inst_data=imem_rsp_data and inst_pc=pc; set pc=pc+4; go to HOLD.
  - On imem_rsp_valid with drop=1: discard the data, clear drop, go to REQ (pc already holds the redirect target).
  - Counter reaches MAX_WAIT with no response: go to FAULT, cause=TIMEOUT.
- HOLD: on inst_ready go to REQ. Response-to-inst_valid latency is 1 cycle.
- Fetch rate: one instruction per 3 cycles minimum (REQ, WAIT, HOLD), assuming ready memory and decode.
- PC arithmetic: unsigned modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000 with no fault.
- Redirect (evaluated in IDLE, REQ, WAIT and HOLD; ignored in FAULT):
  - redirect_pc[1:0]!=0: go to FAULT with cause=MISALIGN; pc is unchanged.
  - REQ, request not accepted this cycle: pc=redirect_pc, stay in REQ.
  - REQ, request accepted the same cycle: pc=redirect_pc, drop=1, go to WAIT.
  - WAIT: pc=redirect_pc, drop=1. Memory cannot be cancelled, so the controller stays in WAIT. A redirect in the same cycle as the response overrides the latch: the response is discarded and the controller goes to REQ.
  - HOLD: the held instruction is killed (an inst_ready in the same cycle still counts as consumed); pc=redirect_pc, go to REQ.
  - IDLE: pc=redirect_pc.
- FAULT:
  - fault_cause holds its value.
  - imem_rsp_valid is ignored and drop is cleared.
  - fault_clear: go to REQ at the current pc; cause returns to 0 on the next cycle.
- rst mid-operation aborts any state immediately. An outstanding memory response is the memory's responsibility to squash.
- Only one request may be outstanding at any time.

Decomposition:
- fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD, FAULT);
  - fault-cause constants (CAUSE_NONE=0, CAUSE_MISALIGN=1, CAUSE_TIMEOUT=2);
  - the instruction-width constant (32) and the PC step constant (4).
- One natural sub-module, fetch_wdog: the MAX_WAIT timeout counter.
  - Inputs: clk, rst, clr, en.
  - Output: expired.

Test Plan:
- Reset release with RESET_VEC=32'h100 and memory/decode always ready:
  - imem_addr sequence is 0x100, 0x104, 0x108.
  - inst_pc/inst_data match each address.
  - inst_valid is high one cycle per 3-cycle fetch.
- Decode stall (inst_ready=0 for 5 cycles):
  - inst_valid, inst_data and inst_pc are stable throughout.
  - No new imem_req_valid is issued.
  - Fetch resumes at pc+4 after inst_ready.
- Redirect to 0x2000 during WAIT:
  - The response from 0x104 is discarded (inst_valid stays 0).
  - The next imem_addr is 0x2000.
  - The next inst_pc is 0x2000.
- Redirect to 0x2002:
  - fault=1, fault_cause=1, imem_req_valid=0.
  - fault_clear resumes at the pre-redirect pc.
- Memory never responds with MAX_WAIT=15:
  - fault=1 and fault_cause=2 exactly 15 cycles after entering WAIT.
  - A late imem_rsp_valid is ignored.
- Wrap-around: redirect to 0xFFFF_FFFC, then fetch; the following imem_addr is 0x0000_0000 with no fault.
